// File: rtl/fifo_4096_40bit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_4096_40bit_ctrl_pkg
// Brief   : Shared sizing defaults for the 4096 x 40 streaming FIFO.
// Revision: 1.0
// ============================================================================
package fifo_4096_40bit_ctrl_pkg;

  localparam int FIFO_AWIDTH = 12;
  localparam int FIFO_DEPTH  = 1 << FIFO_AWIDTH;
  localparam int FIFO_DWIDTH = 40;
  // level spans 0..DEPTH inclusive, hence one bit more than the address
  localparam int FIFO_LWIDTH = FIFO_AWIDTH + 1;

endpackage
`default_nettype wire

// File: rtl/dpram_4096_40bit.sv
`default_nettype none
// ============================================================================
// Module  : dpram_4096_40bit
// Brief   : True dual-port RAM, registered read on both ports.
// Revision: 1.0
// ============================================================================
module dpram_4096_40bit
  import fifo_4096_40bit_ctrl_pkg::*;
#(
  parameter int AWIDTH = FIFO_AWIDTH,
  parameter int DWIDTH = FIFO_DWIDTH
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] din_a,
  output logic [DWIDTH-1:0] dout_a,
  input  logic              we_b,
  input  logic [AWIDTH-1:0] addr_b,
  input  logic [DWIDTH-1:0] din_b,
  output logic [DWIDTH-1:0] dout_b
);

`ifdef HARD_MEM
  hard_mem_4096x40 u_hard_mem (
    .clka  (clk),
    .wea   (we_a),
    .addra (addr_a),
    .dina  (din_a),
    .douta (dout_a),
    .clkb  (clk),
    .web   (we_b),
    .addrb (addr_b),
    .dinb  (din_b),
    .doutb (dout_b)
  );
`else
  logic [DWIDTH-1:0] mem_q [0:(1<<AWIDTH)-1];
  logic [DWIDTH-1:0] dout_a_q;
  logic [DWIDTH-1:0] dout_b_q;

  always_ff @(posedge clk) begin
    if (we_a) mem_q[addr_a] <= din_a;
    if (we_b) mem_q[addr_b] <= din_b;
    dout_a_q <= mem_q[addr_a];
    dout_b_q <= mem_q[addr_b];
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_4096_40bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_4096_40bit_ctrl
// Brief   : Valid/ready FIFO over a dual-port RAM with a 2-entry prefetch.
// Revision: 1.0
// ============================================================================
module fifo_4096_40bit_ctrl
  import fifo_4096_40bit_ctrl_pkg::*;
#(
  parameter int AWIDTH = FIFO_AWIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DWIDTH = FIFO_DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH:0]   level
);

  localparam int LW = AWIDTH + 1;

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        pf_cnt_q, pf_cnt_d;
  logic [DWIDTH-1:0] pf0_q, pf0_d;
  logic [DWIDTH-1:0] pf1_q, pf1_d;

  logic              push;
  logic              pop;
  logic              issue;
  logic [1:0]        pf_base;
  logic [DWIDTH-1:0] ram_rdata;
  logic [DWIDTH-1:0] ram_dout_a_unused;

  assign level     = mem_cnt_q + LW'(inflight_q) + LW'(pf_cnt_q);
  assign in_ready  = (level < LW'(DEPTH));
  assign out_valid = (pf_cnt_q != 2'd0);
  assign out_data  = pf0_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Only issue when the slot the return will land in is guaranteed free.
  assign issue = (mem_cnt_q != '0) &&
                 (({1'b0, pf_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  // Occupancy left after this cycle's pop; a returning read lands at this slot.
  assign pf_base = pf_cnt_q - {1'b0, pop};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_cnt_d  = mem_cnt_q + LW'(push) - LW'(issue);
    inflight_d = issue;
    pf_cnt_d   = pf_base + {1'b0, inflight_q};
    pf0_d      = pf0_q;
    pf1_d      = pf1_q;

    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

    if (pop) pf0_d = pf1_q;
    if (inflight_q) begin
      if (pf_base == 2'd0) pf0_d = ram_rdata;
      else                 pf1_d = ram_rdata;
    end

    // Flush wins over any same-cycle push, pop or read return.
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mem_cnt_d  = '0;
      inflight_d = 1'b0;
      pf_cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      pf_cnt_q   <= 2'd0;
      pf0_q      <= '0;
      pf1_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      pf_cnt_q   <= pf_cnt_d;
      pf0_q      <= pf0_d;
      pf1_q      <= pf1_d;
    end
  end

  dpram_4096_40bit #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk    (clk),
    .we_a   (push & ~clear),
    .addr_a (wr_ptr_q),
    .din_a  (in_data),
    .dout_a (ram_dout_a_unused),
    .we_b   (1'b0),
    .addr_b (rd_ptr_q),
    .din_b  ('0),
    .dout_b (ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_4096_40bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_4096_40bit_ctrl
// Brief   : Directed and scoreboarded checks for fifo_4096_40bit_ctrl.
// Revision: 1.0
// ============================================================================
module tb_fifo_4096_40bit_ctrl;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int DW    = 40;
  localparam int LW    = AW + 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          clear     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_4096_40bit_ctrl #(
    .AWIDTH (AW),
    .DEPTH  (DEPTH),
    .DWIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  task automatic test_reset;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (level !== LW'(0)) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
  endtask

  task automatic test_single;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h00DEADBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== LW'(1)) begin errors++; $display("FAIL single_e0 valid %b level %0d want 0/1", out_valid, level); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_e1_valid got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_e2_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 40'h00DEADBEEF) begin errors++; $display("FAIL single_data got %h want 00deadbeef", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (level !== LW'(0) || out_valid !== 1'b0) begin errors++; $display("FAIL single_pop level %0d valid %b want 0/0", level, out_valid); end
  endtask

  task automatic test_stream;
    int sent = 0;
    int recv = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 10100 && recv < 10000; k++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++; if (out_data !== {8'h55, 32'(recv)}) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", recv, out_data, {8'h55, 32'(recv)}); end
        checks++; if (k !== recv + 3) begin errors++; $display("FAIL stream_rate[%0d] arrived cycle %0d want %0d", recv, k, recv + 3); end
        recv++;
      end
      if (sent < 10000) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = {8'h55, 32'(sent)};
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (recv !== 10000) begin errors++; $display("FAIL stream_count got %0d want 10000", recv); end
    @(negedge clk);
    checks++; if (level !== LW'(0)) begin errors++; $display("FAIL stream_level_end got %0d want 0", level); end
    out_ready = 1'b0;
  endtask

  task automatic test_full;
    int recv = 0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready[%0d] got %b want 1", i, in_ready); end
      in_valid = 1'b1; in_data = {8'hA0, 32'(i)};
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 40'hBADBADBAD0;
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL full_level got %0d want 4096", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (level !== LW'(DEPTH) || in_ready !== 1'b0) begin errors++; $display("FAIL full_overflow level %0d ready %b want 4096/0", level, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4300 && recv < DEPTH; k++) begin
      if (out_valid) begin
        checks++; if (out_data !== {8'hA0, 32'(recv)}) begin errors++; $display("FAIL full_drain[%0d] got %h want %h", recv, out_data, {8'hA0, 32'(recv)}); end
        recv++;
      end
      @(negedge clk);
    end
    checks++; if (recv !== DEPTH) begin errors++; $display("FAIL full_drain_count got %0d want 4096", recv); end
    checks++; if (level !== LW'(0) || out_valid !== 1'b0) begin errors++; $display("FAIL full_drain_end level %0d valid %b want 0/0", level, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [DW-1:0] q[$];
    logic [DW-1:0] held = '0;
    logic          stalled = 1'b0;
    logic [DW-1:0] exp;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      checks++; if (level !== LW'(q.size())) begin errors++; $display("FAIL rand_level cycle %0d got %0d want %0d", c, level, q.size()); end
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL rand_stall cycle %0d got %b/%h want 1/%h", c, out_valid, out_data, held); end
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = DW'({$urandom, $urandom});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_extra cycle %0d got %h want none", c, out_data);
        end else begin
          exp = q.pop_front();
          checks++; if (out_data !== exp) begin errors++; $display("FAIL rand_data cycle %0d got %h want %h", c, out_data, exp); end
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5000 && q.size() != 0; k++) begin
      if (out_valid) begin
        exp = q.pop_front();
        checks++; if (out_data !== exp) begin errors++; $display("FAIL rand_drain got %h want %h", out_data, exp); end
      end
      @(negedge clk);
    end
    checks++; if (q.size() !== 0 || level !== LW'(0)) begin errors++; $display("FAIL rand_end left %0d level %0d want 0/0", q.size(), level); end
    out_ready = 1'b0;
  endtask

  task automatic test_clear;
    out_ready = 1'b0;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {8'hC0, 32'(i)};
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (level !== LW'(101)) begin errors++; $display("FAIL clear_fill got %0d want 101", level); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (level !== LW'(100)) begin errors++; $display("FAIL clear_pre_level got %0d want 100", level); end
    clear = 1'b1; in_valid = 1'b1; in_data = 40'h77; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (level !== LW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clear_now level %0d valid %b ready %b want 0/0/1", level, out_valid, in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (level !== LW'(0) || out_valid !== 1'b0) begin errors++; $display("FAIL clear_stale level %0d valid %b want 0/0", level, out_valid); end
    in_valid = 1'b1; in_data = 40'h1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 40'h1) begin errors++; $display("FAIL clear_repush got %b/%h want 1/0000000001", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (level !== LW'(0)) begin errors++; $display("FAIL clear_end_level got %0d want 0", level); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {8'hE0, 32'(i)};
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (level !== LW'(5) || out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre level %0d valid %b want 5/1", level, out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (level !== LW'(0) || out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL areset_now level %0d valid %b data %h want 0/0/0", level, out_valid, out_data); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || level !== LW'(0)) begin errors++; $display("FAIL areset_after ready %b level %0d want 1/0", in_ready, level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_full();
    test_random();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
